// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller for the MEM stage.
// Misses stall the pipeline while a 256-bit line is written back and/or fetched.
//
// state         | meaning
// S_IDLE        | serve hits combinationally; a miss raises stall and leaves IDLE
// S_WRITEBACK   | dirty victim line sent to memory, wait for ack
// S_ALLOCATE    | requested line fetched from memory, written on ack
// S_REFILL_DONE | one settling cycle, stall held, back to IDLE where the access hits
module dcache_ctrl #(
    parameter int INDEX_BITS = 5,
    parameter int LINE_BITS  = 256,
    parameter int TAG_BITS   = 32 - INDEX_BITS - 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_data_i,
    input  logic                 cpu_MemRead_i,
    input  logic                 cpu_MemWrite_i,
    output logic [31:0]          cpu_data_o,
    output logic                 cpu_stall_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);
    localparam int SETS = 1 << INDEX_BITS;

    typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE, S_REFILL_DONE} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [TAG_BITS-1:0]  r_tag   [SETS];
    logic [LINE_BITS-1:0] r_data  [SETS];
    logic [SETS-1:0]      r_valid;
    logic [SETS-1:0]      r_dirty;

    logic [TAG_BITS-1:0]   w_tag;
    logic [INDEX_BITS-1:0] w_index;
    logic [2:0]            w_word;
    logic                  w_req;
    logic                  w_hit;
    logic                  w_store_hit;
    logic                  w_refill;
    logic                  w_unused;

    assign w_tag       = cpu_addr_i[31 -: TAG_BITS];
    assign w_index     = cpu_addr_i[5 +: INDEX_BITS];
    assign w_word      = cpu_addr_i[4:2];
    assign w_unused    = ^cpu_addr_i[1:0];
    assign w_req       = cpu_MemRead_i | cpu_MemWrite_i;
    assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
    // Reset gates array writes so an abandoned miss leaves no trace.
    assign w_store_hit = !rst_i && (r_state == S_IDLE) && cpu_MemWrite_i && w_hit;
    assign w_refill    = !rst_i && (r_state == S_ALLOCATE) && mem_ack_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            r_state <= w_next;
            if (w_refill) begin
                r_valid[w_index] <= 1'b1;
                r_dirty[w_index] <= 1'b0;
            end else if (w_store_hit) begin
                r_dirty[w_index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_refill) begin
            r_tag[w_index]  <= w_tag;
            r_data[w_index] <= mem_data_i;
        end else if (w_store_hit) begin
            r_data[w_index][{w_word, 5'b0} +: 32] <= cpu_data_i;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req && !w_hit)
                    w_next = (r_valid[w_index] && r_dirty[w_index]) ? S_WRITEBACK : S_ALLOCATE;
            end
            S_WRITEBACK:   if (mem_ack_i) w_next = S_ALLOCATE;
            S_ALLOCATE:    if (mem_ack_i) w_next = S_REFILL_DONE;
            default:       w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_stall_o  = 1'b0;
        cpu_data_o   = '0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        if (!rst_i) begin
            case (r_state)
                S_IDLE: begin
                    cpu_stall_o = w_req && !w_hit;
                    if (cpu_MemRead_i && !cpu_MemWrite_i && w_hit)
                        cpu_data_o = r_data[w_index][{w_word, 5'b0} +: 32];
                end
                S_WRITEBACK: begin
                    cpu_stall_o  = 1'b1;
                    mem_enable_o = 1'b1;
                    mem_write_o  = 1'b1;
                    mem_addr_o   = {r_tag[w_index], w_index, 5'b0};
                    mem_data_o   = r_data[w_index];
                end
                S_ALLOCATE: begin
                    cpu_stall_o  = 1'b1;
                    mem_enable_o = 1'b1;
                    mem_addr_o   = {w_tag, w_index, 5'b0};
                end
                default: cpu_stall_o = 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: a flat golden memory plus per-set valid/tag/dirty model predicts
// hits, miss stall lengths, memory traffic and load data; a latency-randomised memory responds.
module tb_dcache_ctrl;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
    logic         cpu_rd, cpu_wr;
    logic         stall, mem_en, mem_we, mem_ack;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata, mem_rdata;

    int checks = 0;
    int fails  = 0;

    dcache_ctrl dut (
        .clk_i(clk), .rst_i(rst),
        .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_wdata),
        .cpu_MemRead_i(cpu_rd), .cpu_MemWrite_i(cpu_wr),
        .cpu_data_o(cpu_rdata), .cpu_stall_o(stall),
        .mem_enable_o(mem_en), .mem_write_o(mem_we),
        .mem_addr_o(mem_addr), .mem_data_o(mem_wdata),
        .mem_data_i(mem_rdata), .mem_ack_i(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Off-chip memory words and the CPU-visible golden overlay (words stored but not yet written back).
    logic [31:0] dram [int];
    logic [31:0] gold [int];

    function automatic logic [31:0] init_word(int w);
        return (w * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction
    function automatic logic [31:0] dram_word(int w);
        if (dram.exists(w)) return dram[w];
        return init_word(w);
    endfunction
    function automatic logic [31:0] gold_word(int w);
        if (gold.exists(w)) return gold[w];
        return dram_word(w);
    endfunction
    function automatic logic [255:0] gold_line(logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = gold_word(int'(a[31:5]) * 8 + i);
        return l;
    endfunction

    // Cache contents model: which line each set holds and whether it was modified.
    bit          mv [32];
    bit          md [32];
    logic [21:0] mt [32];

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [255:0] data;
        int           lat;
    } req_t;
    req_t log_q[$];

    int cnt = 0, cur_lat = 0, force_lat = 0;

    // Memory responder: ack pulses in the Nth cycle of a continuously held request.
    always @(posedge clk) begin
        #2;
        if (rst) begin
            mem_ack = 1'b0;
            cnt = 0;
        end else begin
            if (mem_ack) begin
                mem_ack = 1'b0;
                cnt = 0;
            end
            if (mem_en) begin
                if (cnt == 0) begin
                    cur_lat = (force_lat > 0) ? force_lat : int'($urandom_range(1, 4));
                    log_q.push_back('{mem_we, mem_addr, mem_wdata, cur_lat});
                end
                cnt++;
                if (cnt == cur_lat) begin
                    mem_ack = 1'b1;
                    for (int i = 0; i < 8; i++) begin
                        if (mem_we) dram[int'(mem_addr[31:5]) * 8 + i] = mem_wdata[i*32 +: 32];
                        else mem_rdata[i*32 +: 32] = dram_word(int'(mem_addr[31:5]) * 8 + i);
                    end
                end
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (rst) begin
            chk("reset_outputs", {cpu_rdata, stall, mem_en, mem_we, mem_addr}, '0);
            chk("reset_line_out", mem_wdata, '0);
        end else begin
            if (!mem_en) chk("bus_quiet", {mem_we, mem_addr, mem_wdata}, '0);
            else chk("line_aligned", mem_addr[4:0], 5'd0);
            if (!cpu_rd && !cpu_wr) chk("no_req", {stall, cpu_rdata}, '0);
            else if (!stall && cpu_rd && !cpu_wr)
                chk("load_data", cpu_rdata, gold_word(int'(cpu_addr[31:2])));
        end
    end

    task automatic access(input logic [31:0] a, input logic rd, input logic wr,
                          input logic [31:0] d, output int scyc, output logic [31:0] rdat);
        int           idx;
        logic [21:0]  tg;
        bit           hit, dvict;
        logic [31:0]  vaddr;
        logic [255:0] vline;
        idx   = int'(a[9:5]);
        tg    = a[31:10];
        hit   = mv[idx] && (mt[idx] == tg);
        dvict = !hit && mv[idx] && md[idx];
        vaddr = {mt[idx], a[9:5], 5'b0};
        vline = gold_line(vaddr);
        @(posedge clk);
        #1;
        log_q.delete();
        cpu_addr = a; cpu_rd = rd; cpu_wr = wr; cpu_wdata = d;
        scyc = 0;
        @(negedge clk);
        while (stall && scyc < 100) begin
            scyc++;
            @(negedge clk);
        end
        if (stall) chk("stall_timeout", 1, 0);
        rdat = cpu_rdata;
        if (hit) begin
            chk("hit_stall", scyc, 0);
            chk("hit_no_mem", log_q.size(), 0);
        end else if (!dvict) begin
            chk("clean_req_count", log_q.size(), 1);
            if (log_q.size() == 1) begin
                chk("fetch_req", {log_q[0].we, log_q[0].addr}, {1'b0, tg, a[9:5], 5'b0});
                chk("clean_stall", scyc, log_q[0].lat + 2);
            end
        end else begin
            chk("dirty_req_count", log_q.size(), 2);
            if (log_q.size() == 2) begin
                chk("wb_req", {log_q[0].we, log_q[0].addr}, {1'b1, vaddr});
                chk("wb_data", log_q[0].data, vline);
                chk("fetch_req", {log_q[1].we, log_q[1].addr}, {1'b0, tg, a[9:5], 5'b0});
                chk("dirty_stall", scyc, log_q[0].lat + log_q[1].lat + 2);
            end
        end
        if (!hit) begin
            mv[idx] = 1'b1;
            mt[idx] = tg;
            md[idx] = 1'b0;
        end
        if (wr) begin
            md[idx] = 1'b1;
            gold[int'(a[31:2])] = d;
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          s;
        logic [31:0] r;
        rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
        cpu_addr = '0; cpu_wdata = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        for (int i = 0; i < 32; i++) begin mv[i] = 0; md[i] = 0; mt[i] = '0; end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) dram[16 + i] = 32'h0;
        dram[18] = 32'hDEADBEEF;

        force_lat = 3;
        access(32'h0000_0040, 1, 0, 0, s, r);
        chk("first_miss_stall", s, 5);
        chk("first_miss_req", {log_q.size(), log_q[0].we, log_q[0].addr}, {32'd1, 1'b0, 32'h40});
        chk("first_load_word0", r, 32'h0);
        force_lat = 0;
        access(32'h0000_0048, 1, 0, 0, s, r);
        chk("hit_deadbeef", {s, r}, {32'd0, 32'hDEADBEEF});
        access(32'h0000_0044, 0, 1, 32'hCAFEF00D, s, r);
        force_lat = 2;
        access(32'h0000_0444, 1, 0, 0, s, r);
        chk("evict_stall", s, 6);
        if (log_q.size() == 2) begin
            chk("evict_wb_addr", {log_q[0].we, log_q[0].addr}, {1'b1, 32'h40});
            chk("evict_wb_word1", log_q[0].data[63:32], 32'hCAFEF00D);
            chk("evict_fetch_addr", {log_q[1].we, log_q[1].addr}, {1'b0, 32'h440});
        end
        force_lat = 0;
        access(32'h0000_0040, 1, 0, 0, s, r);
        chk("clean_victim_no_wb", {log_q.size(), log_q[0].we}, {32'd1, 1'b0});
        chk("reload_word0", r, 32'h0);
        idle(1);

        // Reset while a fetch is outstanding.
        force_lat = 20;
        @(posedge clk);
        #1 cpu_addr = 32'h0000_0100; cpu_rd = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1; cpu_rd = 1'b0;
        for (int i = 0; i < 32; i++) begin mv[i] = 0; md[i] = 0; end
        gold.delete();
        @(posedge clk);
        #1 rst = 1'b0; force_lat = 0;
        @(negedge clk);
        chk("after_reset_quiet", {mem_en, stall}, 2'b00);
        access(32'h0000_0100, 1, 0, 0, s, r);
        chk("reaccess_misses", (s > 0), 1'b1);
        access(32'h0000_0040, 1, 0, 0, s, r);
        chk("post_reset_miss", (s > 0), 1'b1);

        // Read and write together behave as a store.
        access(32'h0000_0080, 1, 1, 32'h1234_5678, s, r);
        access(32'h0000_0480, 1, 0, 0, s, r);
        chk("both_high_wb", {log_q.size(), log_q[0].we, log_q[0].addr}, {32'd2, 1'b1, 32'h80});
        chk("both_high_word0", log_q[0].data[31:0], 32'h1234_5678);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            int          op;
            a  = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
            op = int'($urandom_range(0, 2));
            access(a, op != 1, op != 0, $urandom, s, r);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(0, 2)));
        end
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
